// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: TX/RX byte FIFOs between the host bus and a uart core, with a TX handshake FSM
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  wr_err,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overrun,
  input  logic                  clr_overrun,
  output logic                  uart_en,
  output logic                  uart_we,
  output logic [7:0]            uart_data_in,
  input  logic                  uart_tx_busy,
  input  logic                  uart_rx_done,
  input  logic [7:0]            uart_data_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0] cnt_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY} state_t;
  state_t state, state_nx;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_full;
  assign uart_en  = enable;
  assign tx_full  = tx_count == cnt_t'(DEPTH);
  assign rx_full  = rx_count == cnt_t'(DEPTH);
  assign rx_empty = rx_count == '0;
  assign rd_data  = rx_mem[rx_rp];
  assign tx_push  = wr_en && !tx_full;
  assign tx_pop   = state == T_IDLE && enable && tx_count != '0;
  assign rx_push  = uart_rx_done && !rx_full;
  assign rx_pop   = rd_en && !rx_empty;
  always_comb begin
    state_nx = state;
    state_nx = tx_pop ? T_REQ :
               (state == T_REQ && uart_tx_busy) ? T_BUSY :
               (state == T_BUSY && !uart_tx_busy) ? T_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_data;
    if (rx_push) rx_mem[rx_wp] <= uart_data_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= T_IDLE;
      tx_wp        <= '0;
      tx_rp        <= '0;
      tx_count     <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_count     <= '0;
      wr_err       <= 1'b0;
      rx_overrun   <= 1'b0;
      uart_we      <= 1'b0;
      uart_data_in <= '0;
    end else begin
      state      <= state_nx;
      wr_err     <= wr_en && tx_full;
      rx_overrun <= (uart_rx_done && rx_full) || (rx_overrun && !clr_overrun);
      tx_wp      <= tx_wp + ptr_t'(tx_push);
      tx_rp      <= tx_rp + ptr_t'(tx_pop);
      tx_count   <= tx_count + cnt_t'(tx_push) - cnt_t'(tx_pop);
      rx_wp      <= rx_wp + ptr_t'(rx_push);
      rx_rp      <= rx_rp + ptr_t'(rx_pop);
      rx_count   <= rx_count + cnt_t'(rx_push) - cnt_t'(rx_pop);
      if (tx_pop) begin
        uart_we      <= 1'b1;
        uart_data_in <= tx_mem[tx_rp];
      end else if (state == T_REQ && uart_tx_busy) uart_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed bench with a simple uart TX model and immediate-assertion checks
module tb_uart_fifo_bridge;
  logic clk = 0, rst_n = 0, enable = 0, wr_en = 0, rd_en = 0, clr_overrun = 0;
  logic uart_tx_busy = 0, uart_rx_done = 0;
  logic [7:0] wr_data = 0, uart_data_out = 0;
  logic tx_full, wr_err, rx_empty, rx_overrun, uart_en, uart_we;
  logic [4:0] tx_count, rx_count;
  logic [7:0] rd_data, uart_data_in;
  int checks = 0, failures = 0;
  logic [7:0] got [$];

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .wr_err(wr_err), .rd_en(rd_en),
    .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count), .rx_overrun(rx_overrun),
    .clr_overrun(clr_overrun), .uart_en(uart_en), .uart_we(uart_we),
    .uart_data_in(uart_data_in), .uart_tx_busy(uart_tx_busy),
    .uart_rx_done(uart_rx_done), .uart_data_out(uart_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart model: busy rises 20 cycles after a request is seen, falls 200 cycles later
  initial forever begin
    @(negedge clk);
    if (rst_n && uart_we && !uart_tx_busy) begin
      got.push_back(uart_data_in);
      repeat (20) @(negedge clk);
      uart_tx_busy = 1;
      @(negedge clk);
      chk("we_drop_after_busy", uart_we, 0);
      repeat (199) @(negedge clk);
      uart_tx_busy = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] b);
    wr_en = 1; wr_data = b; @(negedge clk); wr_en = 0;
  endtask
  task automatic rx(input logic [7:0] b);
    uart_rx_done = 1; uart_data_out = b; @(negedge clk); uart_rx_done = 0;
  endtask
  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp); rd_en = 1; @(negedge clk); rd_en = 0;
  endtask
  task automatic wait_got(input int n, input int lim);
    int c = 0;
    while (got.size() < n && c < lim) begin @(negedge clk); c++; end
    chk("wait_got_count", got.size(), n);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_we", uart_we, 0);
    chk("rst_data_in", uart_data_in, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_counts", {tx_count, rx_count}, 0);
    chk("uart_en_follow", uart_en, 0);
    rst_n = 1;
    @(negedge clk);
    // 1: three bytes in order
    push(8'h55); push(8'hA3); push(8'h0F);
    chk("t1_count3", tx_count, 3);
    enable = 1;
    @(negedge clk);
    chk("uart_en_follow1", uart_en, 1);
    chk("t1_count2", tx_count, 2);
    chk("t1_we", uart_we, 1);
    wait_got(2, 400); chk("t1_count1", tx_count, 1);
    wait_got(3, 400); chk("t1_count0", tx_count, 0);
    repeat (250) @(negedge clk);
    chk("t1_episodes", got.size(), 3);
    if (got.size() == 3) chk("t1_order", {got[0], got[1], got[2]}, 24'h55A30F);
    got.delete();
    // 2: fill TX FIFO with enable low, overflow, then drain
    enable = 0;
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    chk("t2_full", tx_full, 1);
    chk("t2_count16", tx_count, 16);
    chk("t2_no_err_yet", wr_err, 0);
    push(8'hEE);
    chk("t2_wr_err", wr_err, 1);
    @(negedge clk);
    chk("t2_wr_err_pulse", wr_err, 0);
    chk("t2_count_hold", tx_count, 16);
    chk("t2_idle_disabled", got.size(), 0);
    enable = 1;
    wait_got(16, 16 * 260);
    repeat (300) @(negedge clk);
    chk("t2_no_extra", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t2_order", got[i], 8'(8'h30 + i));
    got.delete();
    // 3: RX basic
    rx(8'h01); rx(8'h02); rx(8'h03);
    chk("t3_count3", rx_count, 3);
    pop("t3_pop1", 8'h01); pop("t3_pop2", 8'h02); pop("t3_pop3", 8'h03);
    chk("t3_empty", rx_empty, 1);
    rd_en = 1; @(negedge clk); rd_en = 0;
    chk("t3_empty_pop_ignored", rx_count, 0);
    // 4: RX overrun
    for (int i = 0; i < 16; i++) rx(8'(8'h40 + i));
    chk("t4_count16", rx_count, 16);
    rx(8'h99);
    chk("t4_overrun", rx_overrun, 1);
    chk("t4_count_hold", rx_count, 16);
    repeat (3) @(negedge clk);
    chk("t4_overrun_sticky", rx_overrun, 1);
    clr_overrun = 1; @(negedge clk); clr_overrun = 0;
    chk("t4_overrun_clr", rx_overrun, 0);
    for (int i = 0; i < 16; i++) pop("t4_pop", 8'(8'h40 + i));
    chk("t4_empty", rx_empty, 1);
    // 5: simultaneous push and pop
    for (int i = 0; i < 5; i++) rx(8'(8'hA0 + i));
    chk("t5_count5", rx_count, 5);
    chk("t5_head", rd_data, 8'hA0);
    rd_en = 1; uart_rx_done = 1; uart_data_out = 8'h7E;
    @(negedge clk);
    rd_en = 0; uart_rx_done = 0;
    chk("t5_count_same", rx_count, 5);
    for (int i = 1; i < 5; i++) pop("t5_pop", 8'(8'hA0 + i));
    pop("t5_last", 8'h7E);
    chk("t5_empty", rx_empty, 1);
    // 6: async reset while in T_REQ
    enable = 0;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    rx(8'h11); rx(8'h22);
    enable = 1;
    repeat (5) @(negedge clk);
    chk("t6_req_we", uart_we, 1);
    chk("t6_queued4", tx_count, 4);
    #2 rst_n = 0;
    #1;
    chk("t6_async_we", uart_we, 0);
    chk("t6_async_txcount", tx_count, 0);
    chk("t6_async_rxempty", rx_empty, 1);
    @(negedge clk);
    rst_n = 1;
    begin
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (uart_we !== 1'b0 || tx_count !== 5'd0) bad++;
      end
      chk("t6_stays_idle", bad, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
